// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR for the DDS modulation path: multi-shift advance,
// run-time seed load with all-zero lock-up protection and a sequence-wrap pulse.

module lfsr_step #(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = 5'h05
) (
   input  logic [WIDTH-1:0] s_in,
   output logic [WIDTH-1:0] s_out
);
   // Feedback enters the MSB, the rest shifts toward bit 0.
   assign s_out = {^(s_in & TAPS), s_in[WIDTH-1:1]};
endmodule

module lfsr_gen #(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = 5'h05,
   parameter logic [WIDTH-1:0] SEED  = 5'h01,
   parameter int               STEPS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state,
   output logic             rnd_bit,
   output logic             wrap,
   output logic             lockup_err
);

   generate
      if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
         $error("lfsr_gen: WIDTH must be in 3..32");
      end
      if (TAPS == '0) begin : g_bad_taps
         $error("lfsr_gen: TAPS must be nonzero");
      end
      if (SEED == '0) begin : g_bad_seed
         $error("lfsr_gen: SEED must be nonzero");
      end
      if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
         $error("lfsr_gen: STEPS must be in 1..WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0]            start_reg;
   logic [STEPS:0][WIDTH-1:0]   chain;
   logic [WIDTH-1:0]            nxt;

   // Unrolled chain: STEPS single shifts resolved in one cycle.
   assign chain[0] = state;
   for (genvar i = 0; i < STEPS; i++) begin : g_step
      lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
         .s_in  (chain[i]),
         .s_out (chain[i+1])
      );
   end
   assign nxt = chain[STEPS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SEED;
         start_reg  <= SEED;
         wrap       <= 1'b0;
         lockup_err <= 1'b0;
      end else if (load) begin
         // An all-zero load would freeze the register, so fall back to SEED.
         if (load_val != '0) begin
            state     <= load_val;
            start_reg <= load_val;
         end else begin
            state      <= SEED;
            start_reg  <= SEED;
            lockup_err <= 1'b1;
         end
         wrap <= 1'b0;
      end else if (en) begin
         state <= nxt;
         wrap  <= (nxt == start_reg);
      end else begin
         wrap <= 1'b0;
      end
   end

   assign rnd_bit = state[0];

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: the driver queues expected outputs, a monitor
// pops and compares one entry after each clock edge.

module tb_lfsr_gen;
   localparam int W = 5;

   typedef struct packed {
      logic         sel;
      logic [W-1:0] st;
      logic         wr;
      logic         lk;
      logic [15:0]  id;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic         en5 = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] state, state5;
   logic         rnd_bit, rnd_bit5, wrap, wrap5, lockup_err, lockup_err5;

   exp_t         q[$];
   int           vectors = 0;
   int           errors = 0;
   int           nvec = 0;
   logic [W-1:0] seq [31];

   always #5 clk = ~clk;

   lfsr_gen dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .state(state), .rnd_bit(rnd_bit), .wrap(wrap), .lockup_err(lockup_err)
   );

   lfsr_gen #(.STEPS(5)) dut5 (
      .clk(clk), .reset(reset), .en(en5), .load(1'b0), .load_val(5'h00),
      .state(state5), .rnd_bit(rnd_bit5), .wrap(wrap5), .lockup_err(lockup_err5)
   );

   task automatic drive(input logic e, input logic l, input logic e5,
                        input logic [W-1:0] lv, input logic s,
                        input logic [W-1:0] st, input logic wr, input logic lk);
      exp_t x;
      @(negedge clk);
      en = e; load = l; en5 = e5; load_val = lv;
      x.sel = s; x.st = st; x.wr = wr; x.lk = lk; x.id = nvec[15:0];
      q.push_back(x);
      nvec++;
   endtask

   task automatic idle();
      @(negedge clk);
      en = 1'b0; load = 1'b0; en5 = 1'b0; load_val = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: one queued expectation per clock edge.
   initial begin
      exp_t         e;
      logic [W-1:0] gs;
      logic         gw, gl, gr;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() != 0) begin
            e  = q.pop_front();
            gs = e.sel ? state5 : state;
            gw = e.sel ? wrap5 : wrap;
            gl = e.sel ? lockup_err5 : lockup_err;
            gr = e.sel ? rnd_bit5 : rnd_bit;
            vectors++;
            if (gs !== e.st || gw !== e.wr || gl !== e.lk || gr !== e.st[0]) begin
               errors++;
               $display("FAIL vec%0d dut%0d: state=%0d wrap=%b lockup=%b rnd=%b expected state=%0d wrap=%b lockup=%b",
                        e.id, e.sel, gs, gw, gl, gr, e.st, e.wr, e.lk);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      seq = '{5'd16, 5'd8, 5'd4, 5'd18, 5'd9, 5'd20, 5'd26, 5'd13, 5'd6, 5'd19,
              5'd25, 5'd28, 5'd30, 5'd31, 5'd15, 5'd7, 5'd3, 5'd17, 5'd24, 5'd12,
              5'd22, 5'd27, 5'd29, 5'd14, 5'd23, 5'd11, 5'd21, 5'd10, 5'd5, 5'd2,
              5'd1};

      // Reset state
      #12;
      chk("reset_state", 32'(state), 32'd1);
      chk("reset_wrap", 32'(wrap), 32'd0);
      chk("reset_lockup", 32'(lockup_err), 32'd0);
      chk("reset_rnd", 32'(rnd_bit), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // Free run over two full periods
      for (int k = 1; k <= 62; k++)
         drive(1, 0, 0, '0, 0, seq[(k-1)%31], (k % 31) == 0, 0);

      // en toggling 1,0,0,1
      drive(1, 0, 0, '0, 0, 5'd16, 0, 0);
      drive(0, 0, 0, '0, 0, 5'd16, 0, 0);
      drive(0, 0, 0, '0, 0, 5'd16, 0, 0);
      drive(1, 0, 0, '0, 0, 5'd8,  0, 0);

      // Load 18 with en high, then a full period from the new start
      drive(1, 1, 0, 5'h12, 0, 5'd18, 0, 0);
      for (int k = 1; k <= 31; k++)
         drive(1, 0, 0, '0, 0, seq[(3+k)%31], k == 31, 0);

      // All-zero load recovers to SEED and sets the sticky flag
      drive(1, 1, 0, 5'h00, 0, 5'd1, 0, 1);
      drive(0, 1, 0, 5'h04, 0, 5'd4, 0, 1);
      drive(1, 0, 0, '0,    0, 5'd18, 0, 1);
      drive(1, 0, 0, '0,    0, 5'd9,  0, 1);
      idle();
      #3 reset = 1'b0;
      #1;
      chk("pulse_state", 32'(state), 32'd1);
      chk("pulse_lockup", 32'(lockup_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Asynchronous reset mid-cycle after 7 advances
      for (int k = 1; k <= 7; k++)
         drive(1, 0, 0, '0, 0, seq[k-1], 0, 0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'd1);
      chk("async_wrap", 32'(wrap), 32'd0);
      chk("async_rnd", 32'(rnd_bit), 32'd1);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      drive(1, 0, 0, '0, 0, 5'd16, 0, 0);
      drive(0, 0, 0, '0, 0, 5'd16, 0, 0);

      // Five shifts per clock
      for (int k = 1; k <= 31; k++)
         drive(0, 0, 1, '0, 1, seq[(5*k-1)%31], k == 31, 0);
      idle();

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random source for the DDS modulation path. It generates noise, dither and PRBS data symbols for the modulator.
- Generalises the fixed 5-bit generator in four ways: configurable width, tap mask and seed; multiple shifts per clock; run-time seed load with all-zero lock-up protection; and a sequence-wrap pulse for frame alignment.
- With default parameters it reproduces the existing 5-bit sequence exactly.

Parameters:
- WIDTH, 5: register width in bits; legal range 3..32.
- TAPS, 5'h05: feedback tap mask, WIDTH bits; bit i set means state[i] feeds the XOR; must be nonzero.
- SEED, 5'h01: reset value and lock-up recovery value; must be nonzero.
- STEPS, 1: shifts applied per enabled clock; legal range 1..WIDTH.
- Illegal parameter values cause an elaboration error (generate-time check).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: advance the sequence by STEPS shifts this cycle.
- load, input, 1: load load_val as the new state and start point.
- load_val, input, WIDTH: value to load.
- state, output, WIDTH: current LFSR register.
- rnd_bit, output, 1: equals state[0].
- wrap, output, 1: one-cycle pulse when the sequence returns to its start value.
- lockup_err, output, 1: sticky flag, set when an all-zero load was attempted.

Behaviour:
- Single shift function f(s) = {^(s & TAPS), s[WIDTH-1:1]}: the feedback bit enters the MSB and the rest shifts right.
- Advance function F = f applied STEPS times. Implement as a combinational unrolled chain; the result is registered in the same cycle, so latency is 1 clock.
- Internal start_reg (WIDTH bits) holds the value the sequence started from.
- Reset (reset=0, asynchronous, immediate):
  - state = SEED, start_reg = SEED.
  - wrap = 0, lockup_err = 0.
  - Takes effect mid-sequence or mid-load; the register resumes from SEED on the first rising edge after release.
- Priority per rising edge: load > en > hold.
- Load (load=1), en ignored:
  - If load_val != 0: state = load_val, start_reg = load_val, lockup_err unchanged.
  - If load_val == 0: state = SEED, start_reg = SEED, lockup_err = 1.
  - wrap = 0 in the load cycle.
- Advance (load=0, en=1):
  - state = F(state).
  - wrap = 1 iff F(state) == start_reg, else 0.
- Hold (load=0, en=0): state and start_reg unchanged, wrap = 0.
- lockup_err is cleared only by reset.
- The state register never holds all-zero outside reset.
- Wrap timing: with a maximal-length TAPS and gcd(STEPS, 2^WIDTH-1) = 1, wrap fires every 2^WIDTH-1 enabled clocks. Otherwise the wrap period is the orbit length of F; this is documented behaviour, not an error.
- Outputs are registered; rnd_bit is a direct wire from state[0].

Test Plan:
- Defaults, after reset release, en=1 continuously -> state sequence 1,16,8,4,18,9,20,... Exactly 31 distinct nonzero values; wrap pulses for one cycle on enabled clock 31 (state back to 1), then every 31 clocks.
- Defaults, toggle en 1,0,0,1 -> state 16, then held at 16 for two cycles, then 8; wrap stays 0 throughout.
- load=1 with load_val=5'h12 while en=1 -> state=18, wrap=0 in the load cycle. The next enabled clock gives 9; wrap fires on the 31st enabled clock after the load, with state=18.
- load=1 with load_val=0 -> state=1, lockup_err=1 and it stays 1 across further loads and advances; a pulse of reset=0 clears it to 0.
- Instance with STEPS=5, other parameters default, en=1 -> state goes 1 -> 9 in one clock; wrap after 31 enabled clocks.
- Assert reset=0 asynchronously mid-clock after 7 advances -> state=1 immediately, before the next edge; wrap=0; the sequence restarts at 16 on the first enabled edge after release.
